// File: rtl/clause_eval_scheduler.sv
// Clause scan scheduler: issues clause-memory reads, collects evaluator results,
// queues unit implications in a small FIFO and reports pass completion or conflict.
module clause_eval_scheduler #(
    parameter int NUM_VARIABLE = 128,
    parameter int NUM_CLAUSE   = 256,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [$clog2(NUM_CLAUSE)-1:0]   last_clause,
    output logic                            clause_rd_en,
    output logic [$clog2(NUM_CLAUSE)-1:0]   clause_addr,
    input  logic                            eval_unit,
    input  logic                            eval_new_assignment,
    input  logic [$clog2(NUM_VARIABLE)-1:0] eval_implied_variable,
    input  logic                            eval_conflict,
    output logic                            imp_valid,
    input  logic                            imp_ready,
    output logic [$clog2(NUM_VARIABLE)-1:0] imp_variable,
    output logic                            imp_value,
    output logic                            busy,
    output logic                            done,
    output logic                            conflict,
    output logic [$clog2(NUM_CLAUSE)-1:0]   conflict_clause,
    output logic [$clog2(NUM_CLAUSE):0]     unit_count
);

    localparam int VW = $clog2(NUM_VARIABLE);
    localparam int CW = $clog2(NUM_CLAUSE);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
    localparam logic [AW:0]   RESERVE_LVL = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   FULL_LVL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [CW-1:0] ADDR_ONE    = CW'(1);
    localparam logic [CW:0]   UCNT_ONE    = (CW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_CONFL = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   last_q, last_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   inflight_addr_q, inflight_addr_d;
    logic [CW-1:0]   conflict_clause_q, conflict_clause_d;
    logic [CW:0]     unit_count_q, unit_count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [VW:0]     fifo_mem [FIFO_DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic            stall;
    logic            consuming;
    logic [AW:0]     occ_after_pop;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        last_d            = last_q;
        inflight_addr_d   = inflight_addr_q;
        conflict_clause_d = conflict_clause_q;
        unit_count_d      = unit_count_q;
        issue             = 1'b0;
        push              = 1'b0;
        flush             = 1'b0;

        pop           = (count_q != '0) && imp_ready;
        occ_after_pop = pop ? (count_q - CNT_ONE) : count_q;
        // One slot stays free for the result of a read already in flight.
        stall         = (occ_after_pop >= RESERVE_LVL);
        consuming     = inflight_q && ((state_q == S_SCAN) || (state_q == S_DRAIN));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d           = S_SCAN;
                    addr_d            = '0;
                    last_d            = last_clause;
                    unit_count_d      = '0;
                    conflict_clause_d = '0;
                end
            end
            S_SCAN: begin
                issue = !stall;
                if (issue) begin
                    addr_d          = addr_q + ADDR_ONE;
                    inflight_addr_d = addr_q;
                    if (addr_q == last_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CONFL: begin
                state_d = S_IDLE;
                flush   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A conflicting result overrides both the enqueue and any scan progress.
        if (consuming) begin
            if (eval_conflict) begin
                state_d           = S_CONFL;
                conflict_clause_d = inflight_addr_q;
            end else if (eval_unit) begin
                push         = 1'b1;
                unit_count_d = unit_count_q + UCNT_ONE;
            end
        end

        inflight_d = issue;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            last_q            <= '0;
            inflight_q        <= 1'b0;
            inflight_addr_q   <= '0;
            conflict_clause_q <= '0;
            unit_count_q      <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            last_q            <= last_d;
            inflight_q        <= inflight_d;
            inflight_addr_q   <= inflight_addr_d;
            conflict_clause_q <= conflict_clause_d;
            unit_count_q      <= unit_count_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {eval_implied_variable, eval_new_assignment};
        end
    end

    assign clause_rd_en               = issue;
    assign clause_addr                = addr_q;
    assign imp_valid                  = (count_q != '0);
    assign {imp_variable, imp_value}  = fifo_mem[rd_ptr_q];
    assign busy                       = (state_q != S_IDLE);
    assign done                       = (state_q == S_DONE);
    assign conflict                   = (state_q == S_CONFL);
    assign conflict_clause            = conflict_clause_q;
    assign unit_count                 = unit_count_q;

    a_no_push_when_full: assert property (
        @(posedge clock) disable iff (!reset_n) !(push && (count_q == FULL_LVL))
    );

endmodule

// File: tb/tb_clause_eval_scheduler.sv
// Directed bench for clause_eval_scheduler: a table-driven clause evaluator model,
// read/implication monitors and hand-computed expectations per scenario.
module tb_clause_eval_scheduler;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] last_clause;
    logic       clause_rd_en;
    logic [7:0] clause_addr;
    logic       eval_unit;
    logic       eval_new_assignment;
    logic [6:0] eval_implied_variable;
    logic       eval_conflict;
    logic       imp_valid;
    logic       imp_ready;
    logic [6:0] imp_variable;
    logic       imp_value;
    logic       busy;
    logic       done;
    logic       conflict;
    logic [7:0] conflict_clause;
    logic [8:0] unit_count;

    clause_eval_scheduler #(
        .NUM_VARIABLE(128),
        .NUM_CLAUSE  (256),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .start                (start),
        .last_clause          (last_clause),
        .clause_rd_en         (clause_rd_en),
        .clause_addr          (clause_addr),
        .eval_unit            (eval_unit),
        .eval_new_assignment  (eval_new_assignment),
        .eval_implied_variable(eval_implied_variable),
        .eval_conflict        (eval_conflict),
        .imp_valid            (imp_valid),
        .imp_ready            (imp_ready),
        .imp_variable         (imp_variable),
        .imp_value            (imp_value),
        .busy                 (busy),
        .done                 (done),
        .conflict             (conflict),
        .conflict_clause      (conflict_clause),
        .unit_count           (unit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Evaluator model: answers one cycle after each read from these tables.
    logic       unit_tbl  [256];
    logic       confl_tbl [256];
    logic [6:0] var_tbl   [256];
    logic       val_tbl   [256];
    logic       ev_vld = 1'b0;
    logic [7:0] ev_addr = '0;

    always @(posedge clock) begin
        ev_vld  <= clause_rd_en;
        ev_addr <= clause_addr;
    end

    assign eval_unit             = ev_vld & unit_tbl[ev_addr];
    assign eval_conflict         = ev_vld & confl_tbl[ev_addr];
    assign eval_implied_variable = var_tbl[ev_addr];
    assign eval_new_assignment   = val_tbl[ev_addr];

    int         rd_addr_log[$];
    int         rd_cyc_log[$];
    logic [7:0] imp_log[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         confl_cnt = 0;

    always @(negedge clock) begin
        if (clause_rd_en) begin
            rd_addr_log.push_back(int'(clause_addr));
            rd_cyc_log.push_back(cyc);
        end
        if (imp_valid && imp_ready) imp_log.push_back({imp_variable, imp_value});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (conflict) confl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) begin
            unit_tbl[i]  = 1'b0;
            confl_tbl[i] = 1'b0;
            var_tbl[i]   = '0;
            val_tbl[i]   = 1'b0;
        end
    endtask

    task automatic clear_logs();
        rd_addr_log.delete();
        rd_cyc_log.delete();
        imp_log.delete();
        done_cnt  = 0;
        confl_cnt = 0;
        done_cyc  = 0;
    endtask

    task automatic start_pass(input logic [7:0] last, output int sc);
        @(posedge clock);
        #1;
        start       = 1'b1;
        last_clause = last;
        sc          = cyc;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        logic found;
        found = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clock);
            if (done || conflict) begin
                found = 1'b1;
                break;
            end
        end
        check("pass_end_seen", found, 1'b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sc;
        int exp_v;
        clear_tables();
        reset_n     = 1'b0;
        start       = 1'b0;
        last_clause = '0;
        imp_ready   = 1'b0;
        #2;
        check("rst_rd_en", clause_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conflict", conflict, 0);
        check("rst_imp_valid", imp_valid, 0);
        check("rst_conflict_clause", conflict_clause, 0);
        check("rst_unit_count", unit_count, 0);
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Plain pass over clauses 0..3, no units.
        clear_logs();
        imp_ready = 1'b1;
        start_pass(8'd3, sc);
        wait_end(50);
        check("p1_reads", rd_addr_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_addr_log.size(); i++) begin
            check("p1_addr", rd_addr_log[i], i);
            check("p1_addr_cyc", rd_cyc_log[i], sc + 1 + i);
        end
        if (rd_cyc_log.size() == 4) check("p1_done_latency", done_cyc, rd_cyc_log[3] + 2);
        check("p1_done_cnt", done_cnt, 1);
        check("p1_unit_count", unit_count, 0);
        check("p1_done_pulse_end", done, 0);
        check("p1_idle_busy", busy, 0);

        // Units on clauses 2 and 5; a stray start mid-pass must be ignored.
        clear_logs();
        clear_tables();
        unit_tbl[2] = 1'b1; var_tbl[2] = 7'd9;  val_tbl[2] = 1'b1;
        unit_tbl[5] = 1'b1; var_tbl[5] = 7'd40; val_tbl[5] = 1'b0;
        start_pass(8'd7, sc);
        @(posedge clock);
        #1;
        start       = 1'b1;
        last_clause = 8'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_end(50);
        repeat (3) @(posedge clock);
        #1;
        check("p2_reads", rd_addr_log.size(), 8);
        check("p2_imp_cnt", imp_log.size(), 2);
        if (imp_log.size() == 2) begin
            check("p2_imp0", imp_log[0], 8'd19);
            check("p2_imp1", imp_log[1], 8'd80);
        end
        check("p2_unit_count", unit_count, 2);
        check("p2_done_cnt", done_cnt, 1);

        // Every clause a unit with a blocked sink: reads must stall, then resume.
        clear_logs();
        clear_tables();
        for (int i = 0; i < 16; i++) begin
            unit_tbl[i] = 1'b1;
            var_tbl[i]  = 7'(i * 5 + 1);
            val_tbl[i]  = i[0];
        end
        imp_ready = 1'b0;
        start_pass(8'd15, sc);
        repeat (12) @(posedge clock);
        #1;
        check("p3_stall_reads", rd_addr_log.size(), 4);
        check("p3_stall_rd_en", clause_rd_en, 0);
        check("p3_stall_valid", imp_valid, 1);
        check("p3_stall_busy", busy, 1);
        check("p3_stall_units", unit_count, 4);
        imp_ready = 1'b1;
        wait_end(300);
        repeat (8) @(posedge clock);
        #1;
        check("p3_reads", rd_addr_log.size(), 16);
        check("p3_imp_cnt", imp_log.size(), 16);
        for (int i = 0; i < 16 && i < imp_log.size(); i++) begin
            exp_v = ((i * 5 + 1) << 1) | (i & 1);
            check("p3_imp", imp_log[i], exp_v);
        end
        check("p3_unit_count", unit_count, 16);
        check("p3_fifo_empty", imp_valid, 0);

        // Conflict on clause 4 of 0..9 with two units queued behind a blocked sink.
        clear_logs();
        clear_tables();
        unit_tbl[1] = 1'b1; var_tbl[1] = 7'd11; val_tbl[1] = 1'b1;
        unit_tbl[2] = 1'b1; var_tbl[2] = 7'd12; val_tbl[2] = 1'b0;
        unit_tbl[4] = 1'b1; confl_tbl[4] = 1'b1;
        imp_ready = 1'b0;
        start_pass(8'd9, sc);
        wait_end(50);
        check("p4_confl_cnt", confl_cnt, 1);
        check("p4_done_cnt", done_cnt, 0);
        check("p4_conflict_clause", conflict_clause, 4);
        check("p4_reads", rd_addr_log.size(), 6);
        if (rd_addr_log.size() > 0) check("p4_last_addr", rd_addr_log[rd_addr_log.size()-1], 5);
        check("p4_unit_count", unit_count, 2);
        check("p4_flushed", imp_valid, 0);
        check("p4_idle", busy, 0);
        check("p4_pulse_end", conflict, 0);
        repeat (3) @(posedge clock);
        #1;
        check("p4_clause_held", conflict_clause, 4);
        check("p4_no_more_reads", rd_addr_log.size(), 6);

        // Single-clause pass.
        clear_logs();
        clear_tables();
        imp_ready = 1'b1;
        start_pass(8'd0, sc);
        wait_end(20);
        check("p5_reads", rd_addr_log.size(), 1);
        if (rd_addr_log.size() == 1) begin
            check("p5_addr", rd_addr_log[0], 0);
            check("p5_done_latency", done_cyc, rd_cyc_log[0] + 2);
        end
        check("p5_conflict_clause_cleared", conflict_clause, 0);

        // Asynchronous reset mid-scan with queued implications, then a clean pass.
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            unit_tbl[i] = 1'b1;
            var_tbl[i]  = 7'(i + 20);
        end
        imp_ready = 1'b0;
        start_pass(8'd15, sc);
        repeat (4) @(posedge clock);
        #1;
        check("p6_pre_valid", imp_valid, 1);
        check("p6_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("p6_rst_rd_en", clause_rd_en, 0);
        check("p6_rst_busy", busy, 0);
        check("p6_rst_imp_valid", imp_valid, 0);
        check("p6_rst_unit_count", unit_count, 0);
        check("p6_rst_done", done, 0);
        check("p6_rst_conflict", conflict, 0);
        clear_logs();
        clear_tables();
        #2;
        reset_n     = 1'b1;
        imp_ready   = 1'b1;
        start       = 1'b1;
        last_clause = 8'd2;
        sc          = cyc;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_end(30);
        check("p6_reads", rd_addr_log.size(), 3);
        if (rd_cyc_log.size() > 0) check("p6_first_read", rd_cyc_log[0], sc + 1);
        check("p6_unit_count", unit_count, 0);
        check("p6_imp_cnt", imp_log.size(), 0);
        check("p6_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/clause_eval_scheduler.md
CLAUSE_EVAL_SCHEDULER -- requirements
Module: clause_eval_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_VARIABLE, default 128, number of solver variables; VARIABLE_INDEX = clog2(NUM_VARIABLE)-1.
REQ-002 The block SHALL have parameter NUM_CLAUSE, default 256, clause-memory depth; CLAUSE_INDEX = clog2(NUM_CLAUSE)-1.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2), implication FIFO entries.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse; begins a scan pass when in IDLE, ignored otherwise.
REQ-007 last_clause  input  CLAUSE_INDEX+1  index of final clause in the pass, sampled on accepted start.
REQ-008 clause_rd_en / clause_addr  output  1 / CLAUSE_INDEX+1  clause-memory read request; data plus evaluator result valid exactly 1 cycle later.
REQ-009 eval_unit, eval_new_assignment, eval_implied_variable, eval_conflict  input  1/1/VARIABLE_INDEX+1/1  sub-clause evaluator results for the clause read in the previous cycle.
REQ-010 imp_valid, imp_ready, imp_variable, imp_value  out/in/out/out  1/1/VARIABLE_INDEX+1/1  implication stream (valid/ready).
REQ-011 busy, done, conflict  output  1 each  pass active; 1-cycle pass-complete pulse; 1-cycle conflict pulse.
REQ-012 conflict_clause  output  CLAUSE_INDEX+1  index of conflicting clause, held until next accepted start.
REQ-013 unit_count  output  CLAUSE_INDEX+2  unit clauses enqueued in current/last pass.

Function
REQ-014 States SHALL be IDLE, SCAN, DRAIN, DONE, CONFL.
REQ-015 IDLE: start=1 -> SCAN, addr counter=0, unit_count=0, conflict_clause=0; busy=1 from next cycle.
REQ-016 SCAN: clause_rd_en=1 with clause_addr=counter each cycle unless stalled; counter increments on every issued read.
REQ-017 Stall SHALL occur when FIFO occupancy (after this cycle's pop) >= FIFO_DEPTH-1, reserving one slot for the in-flight result; stalled cycle has clause_rd_en=0, counter held.
REQ-018 A 1-bit in-flight flag SHALL track the issued read; its result is consumed in the following cycle only.
REQ-019 Result with eval_conflict=1 SHALL take priority: -> CONFL, conflict_clause=index of that read, no enqueue, no further reads.
REQ-020 Result with eval_unit=1, no conflict: push {eval_implied_variable, eval_new_assignment} into FIFO, unit_count+1.
REQ-021 Issue of clause last_clause SHALL move SCAN -> DRAIN; DRAIN consumes the final result then -> DONE (or CONFL per REQ-019).
REQ-022 DONE: done=1 for exactly one cycle, -> IDLE; FIFO contents preserved and still drained.
REQ-023 CONFL: conflict=1 for exactly one cycle, FIFO flushed (occupancy 0, imp_valid=0 next cycle), -> IDLE.
REQ-024 FIFO: imp_valid = occupancy!=0; pop when imp_valid&imp_ready; simultaneous push and pop on full-minus-reserve SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH; push when full is impossible by REQ-017 and SHALL be flagged by an assertion.
REQ-025 last_clause=0 SHALL yield exactly one read then DRAIN.
REQ-026 start during non-IDLE states SHALL be ignored without side effects.
REQ-027 Latency: start to first clause_rd_en = 1 cycle; final read to done = 2 cycles when unstalled.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, counter=0, in-flight=0, FIFO empty, clause_rd_en=0, busy=0, done=0, conflict=0, imp_valid=0, conflict_clause=0, unit_count=0, including mid-pass.
REQ-029 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-030 last_clause=3, no units, imp_ready=1 -> reads addr 0,1,2,3 on consecutive cycles, done 2 cycles after addr 3, unit_count=0.
REQ-031 last_clause=7, units on clauses 2 and 5 (var 9 val 1, var 40 val 0), imp_ready=1 -> stream (9,1),(40,0) in order, unit_count=2, done pulse.
REQ-032 FIFO_DEPTH=4, every clause unit, imp_ready=0 -> reads stall with occupancy 3 plus 1 in flight, no overflow; imp_ready=1 resumes, all 16 implications delivered for last_clause=15.
REQ-033 eval_conflict on clause 4 of 10 with 2 queued units -> conflict pulse, conflict_clause=4, FIFO empty next cycle, no reads after addr 5, IDLE.
REQ-034 reset_n asserted mid-SCAN with FIFO non-empty -> all outputs at reset values immediately; new start runs a clean pass.
